// File: rtl/stopwatch_bcd_chain.sv
// Multi-digit BCD stopwatch/timer: per-digit maxima, up/down counting, run-control FSM.
// Optional lap capture register is built when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd_chain #(
  parameter int unsigned                NUM_DIGITS = 6,
  parameter logic [4*NUM_DIGITS-1:0]    DIGIT_MAX  = 24'h595999
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    up_down,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [4*NUM_DIGITS-1:0] lap_count,
  output logic                    running,
  output logic                    expired,
  output logic                    wrap
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic           wrap_q,  wrap_d;

  logic [W-1:0]   count_inc;
  logic [W-1:0]   count_dec;
  logic [W-1:0]   load_clamped;
  logic           carry;
  logic           borrow;

  // Whole carry/borrow chain resolves combinationally; carry out of the top digit is the wrap.
  always_comb begin
    count_inc    = count_q;
    count_dec    = count_q;
    load_clamped = load_value;
    carry        = 1'b1;
    borrow       = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == DIGIT_MAX[4*i +: 4]) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = DIGIT_MAX[4*i +: 4];
        end else begin
          count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
      if (load_value[4*i +: 4] > DIGIT_MAX[4*i +: 4]) begin
        load_clamped[4*i +: 4] = DIGIT_MAX[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
      state_d = ST_IDLE;
    end else if (load) begin
      count_d = load_clamped;
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
    end else begin
      if (start && !stop) begin
        if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
          state_d = (!up_down && count_q == '0) ? ST_DONE : ST_RUN;
        end
      end else if (stop && !start) begin
        if (state_q == ST_RUN) begin
          state_d = ST_PAUSE;
        end
      end
      // Any stop request outranks a tick, even when paired with start.
      if (tick && state_q == ST_RUN && !stop) begin
        if (up_down) begin
          count_d = count_inc;
          wrap_d  = carry;
        end else begin
          count_d = count_dec;
          if (count_dec == '0) begin
            state_d = ST_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] lap_q, lap_d;

  // Captures the pre-tick count, so a lap taken on a ticking cycle shows the old value.
  always_comb begin
    lap_d = lap_q;
    if (clear) begin
      lap_d = '0;
    end else if (!load && lap && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
      lap_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_q <= '0;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign lap_count = lap_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_count  = '0;
`endif

  assign count   = count_q;
  assign running = (state_q == ST_RUN);
  assign expired = (state_q == ST_DONE);
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_chain.sv
// Scoreboard bench for stopwatch_bcd_chain: driver queues expected outputs per cycle,
// monitor pops and compares after each rising edge.
module tb_stopwatch_bcd_chain;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        start;
  logic        stop;
  logic        clear;
  logic        load;
  logic [23:0] load_value;
  logic        up_down;
  logic        lap;
  logic [23:0] count;
  logic [23:0] lap_count;
  logic        running;
  logic        expired;
  logic        wrap;

  stopwatch_bcd_chain #(
    .NUM_DIGITS(6),
    .DIGIT_MAX (24'h595999)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .up_down   (up_down),
    .lap       (lap),
    .count     (count),
    .lap_count (lap_count),
    .running   (running),
    .expired   (expired),
    .wrap      (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned cyc;
    logic [23:0] cnt;
    logic [23:0] lapc;
    logic        run;
    logic        expd;
    logic        wr;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic logic [23:0] lapv(input logic [23:0] v);
`ifdef STOPWATCH_LAP_EN
    return v;
`else
    return 24'h0;
`endif
  endfunction

  task automatic push_exp(input logic [23:0] c, input logic [23:0] l,
                          input logic r, input logic e, input logic w);
    exp_t x;
    x.cyc  = cyc + 1;
    x.cnt  = c;
    x.lapc = lapv(l);
    x.run  = r;
    x.expd = e;
    x.wr   = w;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: compare every queued expectation tagged for the edge just taken.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL stale_expectation cycle %0d actual=none required=cycle %0d", cyc, e.cyc);
        end else begin
          chk("count",     count,              e.cnt);
          chk("lap_count", lap_count,          e.lapc);
          chk("running",   {23'h0, running},   {23'h0, e.run});
          chk("expired",   {23'h0, expired},   {23'h0, e.expd});
          chk("wrap",      {23'h0, wrap},      {23'h0, e.wr});
        end
      end
    end
  end

  task automatic step(input logic t, input logic s, input logic p, input logic c,
                      input logic l, input logic [23:0] lv, input logic lp);
    @(negedge clk);
    tick       = t;
    start      = s;
    stop       = p;
    clear      = c;
    load       = l;
    load_value = lv;
    lap        = lp;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; start = 1'b1; stop = 1'b0; clear = 1'b0;
    load = 1'b0; load_value = 24'h0; up_down = 1'b1; lap = 1'b0;

    // Reset dominates tick and start.
    @(negedge clk);
    push_exp(24'h0, 24'h0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; tick = 1'b0; start = 1'b0;

    // Ticks without start are not counted.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 24'h0, 0);
    push_exp(24'h0, 24'h0, 0, 0, 0);

    // Up count from IDLE.
    up_down = 1'b1;
    step(0, 1, 0, 0, 0, 24'h0, 0);
    push_exp(24'h0, 24'h0, 1, 0, 0);
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 0, 0, 0, 24'h0, 0);
      if (i == 9) push_exp(24'h000010, 24'h0, 1, 0, 0);
    end
    push_exp(24'h000100, 24'h0, 1, 0, 0);

    // Wrap from all-max.
    step(0, 0, 0, 0, 1, 24'h595999, 0);
    push_exp(24'h595999, 24'h0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 24'h0, 0);
    push_exp(24'h0, 24'h0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 24'h0, 0);
    push_exp(24'h0, 24'h0, 1, 0, 0);

    // Down count with a multi-digit borrow; load ignores a same-cycle tick.
    up_down = 1'b0;
    step(1, 0, 0, 0, 1, 24'h010000, 0);
    push_exp(24'h010000, 24'h0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 24'h0, 0);
    push_exp(24'h010000, 24'h0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 24'h0, 0);
    push_exp(24'h005999, 24'h0, 1, 0, 0);

    // Expiry.
    step(0, 0, 0, 0, 1, 24'h000002, 0);
    push_exp(24'h000002, 24'h0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 24'h0, 0);
    push_exp(24'h000001, 24'h0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 24'h0, 0);
    push_exp(24'h0, 24'h0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 24'h0, 0);
    push_exp(24'h0, 24'h0, 0, 1, 0);

    // Clamped load; DONE returns to IDLE.
    step(0, 0, 0, 0, 1, 24'hFFFFFF, 0);
    push_exp(24'h595999, 24'h0, 0, 0, 0);

    // Run to 42, pause, lap.
    step(0, 0, 0, 1, 0, 24'h0, 0);
    push_exp(24'h0, 24'h0, 0, 0, 0);
    up_down = 1'b1;
    step(0, 1, 0, 0, 0, 24'h0, 0);
    push_exp(24'h0, 24'h0, 1, 0, 0);
    for (int i = 0; i < 42; i++) step(1, 0, 0, 0, 0, 24'h0, 0);
    push_exp(24'h000042, 24'h0, 1, 0, 0);
    step(1, 0, 1, 0, 0, 24'h0, 0);
    push_exp(24'h000042, 24'h0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 24'h0, 0);
    push_exp(24'h000042, 24'h0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 24'h0, 1);
    push_exp(24'h000042, 24'h000042, 0, 0, 0);
    step(0, 1, 1, 0, 0, 24'h0, 0);
    push_exp(24'h000042, 24'h000042, 0, 0, 0);

    // Resume; lap on a ticking cycle captures the pre-tick value.
    step(0, 1, 0, 0, 0, 24'h0, 0);
    push_exp(24'h000042, 24'h000042, 1, 0, 0);
    step(1, 0, 0, 0, 0, 24'h0, 1);
    push_exp(24'h000043, 24'h000042, 1, 0, 0);
    step(1, 0, 0, 0, 0, 24'h0, 1);
    push_exp(24'h000044, 24'h000043, 1, 0, 0);

    // Clear outranks load.
    step(1, 0, 0, 1, 1, 24'h123456, 1);
    push_exp(24'h0, 24'h0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 24'h0, 0);
    push_exp(24'h0, 24'h0, 0, 0, 0);

    // Lap ignored in IDLE.
    step(0, 0, 0, 0, 1, 24'h000077, 0);
    push_exp(24'h000077, 24'h0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 24'h0, 1);
    push_exp(24'h000077, 24'h0, 0, 0, 0);

    // Down start at zero goes straight to DONE; load leaves DONE.
    step(0, 0, 0, 1, 0, 24'h0, 0);
    push_exp(24'h0, 24'h0, 0, 0, 0);
    up_down = 1'b0;
    step(0, 1, 0, 0, 0, 24'h0, 0);
    push_exp(24'h0, 24'h0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 24'h0, 0);
    push_exp(24'h0, 24'h0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 24'h000005, 0);
    push_exp(24'h000005, 24'h0, 0, 0, 0);

    step(0, 0, 0, 0, 0, 24'h0, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0 pending", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
